// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive/transmit pair: default word width,
// framing state encoding and channel encoding (word-select level).
package i2s_pkg;

    localparam int DATA_W_DEF = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2
    } rx_state_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } chan_t;

endpackage

// File: rtl/lrclk_edge_det.sv
// Word-select edge detector. The first cycle after reset only loads the
// history register, so a reset taken mid-slot never fakes an edge.
module lrclk_edge_det (
    input  logic sclk,
    input  logic rst_n,
    input  logic lrclk,
    output logic lr_edge
);

    logic prev_lr;
    logic primed;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            prev_lr <= 1'b0;
            primed  <= 1'b0;
        end else begin
            prev_lr <= lrclk;
            primed  <= 1'b1;
        end
    end

    assign lr_edge = primed && (lrclk != prev_lr);

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S receiver: deserialises MSB-first words per lrclk slot,
// publishes left/right words, flags pairs and truncated slots.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              lrclk,
    input  logic              sdin,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              left_valid,
    output logic              right_valid,
    output logic              pair_valid,
    output logic              frame_err
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    rx_state_t         state, state_next;
    chan_t             channel;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-2:0] shreg;
    logic [DATA_W-1:0] word;
    logic              left_seen;
    logic              lr_edge;
    logic              start, shift_en, publish, err;

    lrclk_edge_det u_edge (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .lrclk   (lrclk),
        .lr_edge (lr_edge)
    );

    // The final bit is taken straight from sdin so the word lands on the
    // same edge that samples its LSB.
    assign word = {shreg, sdin};

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        shift_en   = 1'b0;
        publish    = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: state_next = WAIT;
            WAIT: begin
                if (lr_edge) begin
                    start      = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                publish = (cnt == '0);
                if (lr_edge) begin
                    // An edge on the LSB cycle is a normal back-to-back slot.
                    start      = 1'b1;
                    err        = (cnt != '0);
                    state_next = SHIFT;
                end else if (cnt == '0) begin
                    state_next = WAIT;
                end else begin
                    shift_en = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            channel     <= LEFT;
            cnt         <= '0;
            shreg       <= '0;
            left_seen   <= 1'b0;
            left_data   <= '0;
            right_data  <= '0;
            left_valid  <= 1'b0;
            right_valid <= 1'b0;
            pair_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            left_valid  <= 1'b0;
            right_valid <= 1'b0;
            pair_valid  <= 1'b0;
            frame_err   <= err;
            if (start) begin
                channel <= chan_t'(lrclk);
                cnt     <= CNT_W'(DATA_W - 1);
                shreg   <= '0;
            end else if (shift_en) begin
                shreg <= word[DATA_W-2:0];
                cnt   <= cnt - 1'b1;
            end
            if (publish) begin
                if (channel == LEFT) begin
                    left_data  <= word;
                    left_valid <= 1'b1;
                    left_seen  <= 1'b1;
                end else begin
                    right_data  <= word;
                    right_valid <= 1'b1;
                    pair_valid  <= left_seen;
                    left_seen   <= 1'b0;
                end
            end
            if (err) left_seen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: slot-level stream model predicts each
// publish / frame error and its cycle; a monitor checks every cycle.
module tb_i2s_receiver;

    localparam int DW = 24;

    logic          sclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lrclk = 1'b1;
    logic          sdin = 1'b0;
    logic [DW-1:0] left_data, right_data;
    logic          left_valid, right_valid, pair_valid, frame_err;

    i2s_receiver #(.DATA_W(DW)) dut (
        .sclk        (sclk),
        .rst_n       (rst_n),
        .lrclk       (lrclk),
        .sdin        (sdin),
        .left_data   (left_data),
        .right_data  (right_data),
        .left_valid  (left_valid),
        .right_valid (right_valid),
        .pair_valid  (pair_valid),
        .frame_err   (frame_err)
    );

    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    // kind: 3'b001 left publish, 3'b010 right publish, 3'b100 frame error
    typedef struct {
        int            cyc;
        logic [2:0]    kind;
        logic [DW-1:0] data;
        logic          pair;
    } ev_t;

    ev_t           sb[$];
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] exp_left = '0;
    logic [DW-1:0] exp_right = '0;

    // stream description and slot-level model state
    bit            s_ch[$];
    int            s_len[$];
    logic [DW-1:0] s_word[$];
    bit            cur_lr = 1'b1;
    bit            m_active = 1'b0;
    int            m_len = 0;
    bit            m_lseen = 1'b0;
    bit            last_bit = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, req);
        end
    endtask

    function automatic ev_t mk_ev(input int c, input logic [2:0] k, input logic [DW-1:0] d, input logic p);
        ev_t e;
        e.cyc = c; e.kind = k; e.data = d; e.pair = p;
        return e;
    endfunction

    task automatic add_slot(input bit ch, input int len, input logic [DW-1:0] w);
        s_ch.push_back(ch);
        s_len.push_back(len);
        s_word.push_back(w);
    endtask

    // Expand queued slots into per-cycle lrclk/sdin, predict events, drive.
    task automatic play(input bit trailing);
        ev_t ev[$];
        bit  lr_a[$];
        bit  bit_a[$];
        int  pos = 0;
        int  base;
        bit  prev = cur_lr;
        for (int s = 0; s < s_ch.size(); s++) begin
            bit ch = s_ch[s];
            if (ch != prev) begin
                if (m_active && m_len < DW) begin
                    ev.push_back(mk_ev(pos, 3'b100, '0, 1'b0));
                    m_lseen = 1'b0;
                end
                m_active = 1'b1;
                m_len    = s_len[s];
                if (s_len[s] >= DW) begin
                    if (!ch) begin
                        ev.push_back(mk_ev(pos + DW, 3'b001, s_word[s], 1'b0));
                        m_lseen = 1'b1;
                    end else begin
                        ev.push_back(mk_ev(pos + DW, 3'b010, s_word[s], m_lseen));
                        m_lseen = 1'b0;
                    end
                end
            end else if (m_active) begin
                m_len += s_len[s];
            end
            prev = ch;
            for (int p = 0; p < s_len[s]; p++) begin
                lr_a.push_back(ch);
                bit_a.push_back(p < DW ? s_word[s][DW-1-p] : 1'($urandom));
            end
            pos += s_len[s];
        end
        base = cyc + 1;
        foreach (ev[k]) begin
            ev[k].cyc += base;
            sb.push_back(ev[k]);
        end
        for (int i = 0; i < lr_a.size(); i++) begin
            lrclk = lr_a[i];
            sdin  = (i == 0) ? last_bit : bit_a[i-1];
            @(negedge sclk);
        end
        last_bit = bit_a[bit_a.size()-1];
        if (trailing) begin
            sdin = last_bit;
            @(negedge sclk);
            for (int i = 0; i < DW + 4; i++) begin
                sdin = 1'($urandom);
                @(negedge sclk);
            end
        end
        cur_lr = prev;
        s_ch.delete();
        s_len.delete();
        s_word.delete();
    endtask

    task automatic do_reset(input bit lr);
        rst_n     = 1'b0;
        lrclk     = lr;
        exp_left  = '0;
        exp_right = '0;
        sb.delete();
        m_active  = 1'b0;
        m_lseen   = 1'b0;
        cur_lr    = lr;
        #1;
        chk("reset_left_data", left_data, '0);
        chk("reset_right_data", right_data, '0);
        chk("reset_pulses", DW'({pair_valid, frame_err, right_valid, left_valid}), '0);
        repeat (3) begin
            sdin = 1'($urandom);
            @(negedge sclk);
        end
        rst_n = 1'b1;
        repeat (2) begin
            sdin = 1'($urandom);
            @(negedge sclk);
        end
    endtask

    // Monitor: one expected event may fall due per cycle; all else idle.
    initial begin
        ev_t        e;
        logic [2:0] ek;
        logic       ep;
        forever begin
            @(posedge sclk);
            #1;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("missed_event", '0, DW'(e.kind));
            end
            ek = 3'b000;
            ep = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e  = sb.pop_front();
                ek = e.kind;
                if (ek == 3'b001) exp_left = e.data;
                if (ek == 3'b010) begin
                    exp_right = e.data;
                    ep        = e.pair;
                end
            end
            chk("pulse_kind", DW'({frame_err, right_valid, left_valid}), DW'(ek));
            chk("pair_valid", DW'(pair_valid), DW'(ep));
            chk("left_data", left_data, exp_left);
            chk("right_data", right_data, exp_right);
        end
    end

    initial begin
        bit ch;
        int r, len;
        do_reset(1'b1);

        // 32-bit slots, fixed words, then random words
        add_slot(1'b0, 32, 24'hA55AC3);
        add_slot(1'b1, 32, 24'h123456);
        add_slot(1'b0, 32, 24'($urandom));
        add_slot(1'b1, 32, 24'($urandom));
        play(1'b1);

        // 24-bit slots: every edge lands on the LSB cycle
        repeat (3) begin
            add_slot(1'b0, 24, 24'h800001);
            add_slot(1'b1, 24, 24'h7FFFFE);
        end
        play(1'b1);

        // truncated slots: error, no pair, left_seen cleared by error
        add_slot(1'b0, 32, 24'($urandom));
        add_slot(1'b1, 32, 24'($urandom));
        add_slot(1'b0, 10, 24'($urandom));
        add_slot(1'b1, 32, 24'($urandom));
        add_slot(1'b0, 32, 24'($urandom));
        add_slot(1'b1, 10, 24'($urandom));
        add_slot(1'b0, 10, 24'($urandom));
        add_slot(1'b1, 32, 24'($urandom));
        add_slot(1'b0, 32, 24'($urandom));
        add_slot(1'b1, 32, 24'($urandom));
        play(1'b1);

        // random slot lengths and words
        ch = ~cur_lr;
        for (int s = 0; s < 24; s++) begin
            r = $urandom_range(0, 9);
            if (s == 23)   len = 32;
            else if (r < 3) len = $urandom_range(3, DW - 1);
            else if (r < 5) len = DW;
            else            len = $urandom_range(DW + 1, 32);
            add_slot(ch, len, 24'($urandom));
            ch = ~ch;
        end
        play(1'b1);

        // reset mid-right-slot with lrclk high, resume mid-slot
        add_slot(1'b0, 32, 24'($urandom));
        add_slot(1'b1, 10, 24'($urandom));
        play(1'b0);
        do_reset(1'b1);
        add_slot(1'b1, 13, 24'($urandom));
        add_slot(1'b0, 32, 24'($urandom));
        add_slot(1'b1, 32, 24'($urandom));
        play(1'b1);

        // stream joined mid-left-slot after reset
        do_reset(1'b0);
        add_slot(1'b0, 9, 24'($urandom));
        add_slot(1'b1, 32, 24'($urandom));
        add_slot(1'b0, 32, 24'($urandom));
        add_slot(1'b1, 24, 24'($urandom));
        play(1'b1);

        repeat (2) @(negedge sclk);
        chk("events_outstanding", DW'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning bits per channel word captured MSB-first.
REQ-002 SHALL have port sclk  input  1  serial bit clock, the block's only clock, all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port lrclk  input  1  word select: 0 = left, 1 = right, synchronous to sclk.
REQ-005 SHALL have port sdin  input  1  serial data from the ADC, Philips I2S format, one-bit delay after each lrclk edge.
REQ-006 SHALL have port left_data  output  DATA_W  last complete left word.
REQ-007 SHALL have port right_data  output  DATA_W  last complete right word.
REQ-008 SHALL have port left_valid  output  1  one-cycle pulse when left_data updates.
REQ-009 SHALL have port right_valid  output  1  one-cycle pulse when right_data updates.
REQ-010 SHALL have port pair_valid  output  1  one-cycle pulse when a right word completes a left+right pair from consecutive slots.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when a slot ends before DATA_W bits were received.

Function
REQ-012 SHALL register lrclk every cycle into prev_lr; edge = (lrclk != prev_lr) while primed.
REQ-013 SHALL implement states IDLE, WAIT, SHIFT.
REQ-014 IDLE: load prev_lr from lrclk, no edge detection, go WAIT next cycle.
REQ-015 WAIT: on edge, latch channel = lrclk, set bit counter to DATA_W-1, clear shift register, go SHIFT; otherwise stay and ignore sdin.
REQ-016 SHIFT: each cycle shift sdin into the LSB of the shift register and decrement the counter; the first sdin bit sampled is the one on the cycle after the edge (MSB).
REQ-017 On the cycle sampling the last bit (counter == 0), SHALL write {shift[DATA_W-2:0], sdin} into left_data or right_data per the latched channel and pulse the matching valid in that same edge, then go WAIT.
REQ-018 Bits after the DATA_W-th in a slot longer than DATA_W (e.g. 32-bit slots) SHALL be ignored.
REQ-019 Edge in SHIFT with counter != 0: SHALL pulse frame_err, leave data outputs unchanged, clear left_seen, restart SHIFT for the new channel (counter = DATA_W-1).
REQ-020 Edge coinciding with counter == 0: SHALL publish the completed word (no frame_err) and restart SHIFT for the new channel in the same cycle.
REQ-021 left_seen flag SHALL set on left publish and clear on right publish or frame_err; pair_valid SHALL pulse with right_valid only if left_seen was set.
REQ-022 Valid and error pulses SHALL be exactly one sclk cycle; data outputs SHALL hold between updates.

Reset
REQ-023 On rst_n low: state IDLE, left_data = right_data = 0, all valid/error outputs 0, counter 0, left_seen 0, prev_lr 0.
REQ-024 Reset mid-word SHALL discard the partial word; no output pulse until a full slot after the first edge seen post-reset.

Structure
REQ-025 DATA_W default, state enum (IDLE/WAIT/SHIFT) and channel enum (LEFT=0/RIGHT=1) SHALL reside in shared package i2s_pkg, also used by i2s_transmitter.
REQ-026 lrclk edge detection with priming SHALL be a sub-module lrclk_edge_det (inputs sclk, rst_n, lrclk; output edge).

Verification
REQ-027 64-sclk frame (32-bit slots), left = 24'hA5_5A_C3, right = 24'h12_34_56 -> left_valid on 25th sclk after the left edge with left_data = A55AC3, then right_valid + pair_valid with right_data = 123456.
REQ-028 24-bit slots (48-sclk frame), words 24'h800001 / 24'h7FFFFE -> edge coincides with LSB, both words published, no frame_err, pair_valid every frame.
REQ-029 lrclk toggles after 10 bits of a left slot -> frame_err pulse, left_data unchanged, following right word publishes with right_valid but no pair_valid.
REQ-030 rst_n pulsed low mid-right-slot while lrclk = 1 -> all outputs 0, no spurious edge, first pulse only after the next full slot.
REQ-031 Start stream in mid-slot after reset -> partial slot ignored, first output aligned to the first lrclk edge.
